// File: rtl/sift_seq_pkg.sv
// -----------------------------------------------------------------------------
// sift_seq_pkg
// Shared definitions for the SIFT phase sequencer:
//   - seq_state_t : sequencer state encoding (also driven out on buffer_mode)
//   - EN_*        : bit positions of the phases inside phase_en
//   - next_phase  : lowest enabled phase after a given state, or S_DONE
// -----------------------------------------------------------------------------
package sift_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_GAUSSIAN = 3'd1,
    S_DETECT   = 3'd2,
    S_MATCH    = 3'd3,
    S_DONE     = 3'd4
  } seq_state_t;

  localparam int unsigned EN_GAUSSIAN = 0;
  localparam int unsigned EN_DETECT   = 1;
  localparam int unsigned EN_MATCH    = 2;

  // Phases always run in the fixed order GAUSSIAN -> DETECT -> MATCH; disabled
  // phases are skipped and the run ends in DONE when nothing further is enabled.
  function automatic seq_state_t next_phase(input seq_state_t cur, input logic [2:0] en);
    seq_state_t nxt;
    nxt = S_DONE;
    case (cur)
      S_IDLE: begin
        if (en[EN_GAUSSIAN])    nxt = S_GAUSSIAN;
        else if (en[EN_DETECT]) nxt = S_DETECT;
        else if (en[EN_MATCH])  nxt = S_MATCH;
        else                    nxt = S_DONE;
      end
      S_GAUSSIAN: begin
        if (en[EN_DETECT])      nxt = S_DETECT;
        else if (en[EN_MATCH])  nxt = S_MATCH;
        else                    nxt = S_DONE;
      end
      S_DETECT: begin
        if (en[EN_MATCH])       nxt = S_MATCH;
        else                    nxt = S_DONE;
      end
      default:                  nxt = S_DONE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/sift_done_collector.sv
// -----------------------------------------------------------------------------
// sift_done_collector
// Sticky per-lane completion collector for the blur-scale engines. Each lane's
// done pulse sets its own sticky bit; all_done reports that every lane has
// finished, including lanes pulsing in the current cycle.
// Ports:
//   clk       : clock
//   rst       : synchronous active-high reset
//   clear     : synchronous clear of all sticky bits
//   lane_done : per-lane completion pulses [N_SCALES]
//   all_done  : every lane has finished (combinational, includes this cycle)
// -----------------------------------------------------------------------------
module sift_done_collector #(
  parameter int N_SCALES = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic [N_SCALES-1:0] lane_done,
  output logic                all_done
);

  logic [N_SCALES-1:0] sticky;

  // Accumulate lane completions until cleared.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      sticky <= {N_SCALES{1'b0}};
    end else begin
      sticky <= sticky | lane_done;
    end
  end

  assign all_done = &(sticky | lane_done);

endmodule

// File: rtl/sift_phase_sequencer.sv
// -----------------------------------------------------------------------------
// sift_phase_sequencer
// Sequences the SIFT pipeline through GAUSSIAN, DETECT and MATCH phases (each
// optionally skipped) and muxes the active engine's memory controls.
// Optional feature: define SIFT_SEQ_TIMEOUT_EN to add a per-phase watchdog
// (TIMEOUT_CYC cycles) that aborts the run and sets a sticky err flag.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start, phase_en     : run request (IDLE only) and phase enables
//   abort               : cancel the current run
//   g_done/d_done/m_done: engine completion pulses
//   g_start/d_start/m_start : phase-active levels
//   g_*/d_* addr/we     : engine memory controls
//   blur_addr/img_addr/buffer_we : muxed memory controls
//   buffer_mode         : current state encoding
//   busy, done, err     : status
// -----------------------------------------------------------------------------
module sift_phase_sequencer
  import sift_seq_pkg::*;
#(
  parameter int N_SCALES    = 4,
  parameter int ADDR_W      = 9,
  parameter int TIMEOUT_CYC = 65535
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [2:0]                 phase_en,
  input  logic                       abort,
  input  logic [N_SCALES-1:0]        g_done,
  input  logic                       d_done,
  input  logic                       m_done,
  output logic                       g_start,
  output logic                       d_start,
  output logic                       m_start,
  input  logic [N_SCALES*ADDR_W-1:0] g_blur_addr,
  input  logic [N_SCALES*ADDR_W-1:0] d_blur_addr,
  input  logic [ADDR_W-1:0]          g_img_addr,
  input  logic [ADDR_W-1:0]          d_img_addr,
  input  logic                       g_buf_we,
  input  logic                       d_buf_we,
  output logic [N_SCALES*ADDR_W-1:0] blur_addr,
  output logic [ADDR_W-1:0]          img_addr,
  output logic                       buffer_we,
  output logic [2:0]                 buffer_mode,
  output logic                       busy,
  output logic                       done,
  output logic                       err
);

  seq_state_t state, next_state;
  logic [2:0] en_q;
  logic       start_accept;
  logic       g_all_done;
  logic       phase_done;
  logic       timeout_hit;

  assign start_accept = (state == S_IDLE) && start && !abort;

  // Sticky lanes are held clear whenever GAUSSIAN is not active, so they are
  // empty on every entry into GAUSSIAN.
  sift_done_collector #(.N_SCALES(N_SCALES)) u_collector (
    .clk       (clk),
    .rst       (rst),
    .clear     (state != S_GAUSSIAN),
    .lane_done (g_done),
    .all_done  (g_all_done)
  );

`ifdef SIFT_SEQ_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt;
  logic             phase_active;
  logic             err_q;

  assign phase_active = (state == S_GAUSSIAN) || (state == S_DETECT) || (state == S_MATCH);
  assign timeout_hit  = phase_active && (cnt == CNT_LIMIT) && !phase_done;
  assign err          = err_q;

  // Per-phase cycle counter, restarted whenever the state changes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= {CNT_W{1'b0}};
    end else if (!phase_active || (next_state != state)) begin
      cnt <= {CNT_W{1'b0}};
    end else begin
      cnt <= cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Sticky watchdog error; a new accepted run clears it.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else if (start_accept) begin
      err_q <= 1'b0;
    end else if (timeout_hit && !abort) begin
      err_q <= 1'b1;
    end else begin
      err_q <= err_q;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign err         = 1'b0;
`endif

  // Completion condition of the phase currently running.
  always_comb begin
    phase_done = 1'b0;
    case (state)
      S_GAUSSIAN: phase_done = g_all_done;
      S_DETECT:   phase_done = d_done;
      S_MATCH:    phase_done = m_done;
      default:    phase_done = 1'b0;
    endcase
  end

  // State register and phase-enable capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
      en_q  <= 3'b000;
    end else begin
      state <= next_state;
      if (start_accept) begin
        en_q <= phase_en;
      end else begin
        en_q <= en_q;
      end
    end
  end

  // Next-state logic; abort has priority over completion and timeout.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE: begin
        if (start_accept) next_state = next_phase(S_IDLE, phase_en);
        else              next_state = S_IDLE;
      end
      S_GAUSSIAN, S_DETECT, S_MATCH: begin
        if (abort)            next_state = S_IDLE;
        else if (phase_done)  next_state = next_phase(state, en_q);
        else if (timeout_hit) next_state = S_IDLE;
        else                  next_state = state;
      end
      S_DONE:  next_state = S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Memory-control mux: only GAUSSIAN and DETECT own the memories.
  always_comb begin
    blur_addr = {(N_SCALES*ADDR_W){1'b0}};
    img_addr  = {ADDR_W{1'b0}};
    buffer_we = 1'b0;
    case (state)
      S_GAUSSIAN: begin
        blur_addr = g_blur_addr;
        img_addr  = g_img_addr;
        buffer_we = g_buf_we;
      end
      S_DETECT: begin
        blur_addr = d_blur_addr;
        img_addr  = d_img_addr;
        buffer_we = d_buf_we;
      end
      default: begin
        blur_addr = {(N_SCALES*ADDR_W){1'b0}};
        img_addr  = {ADDR_W{1'b0}};
        buffer_we = 1'b0;
      end
    endcase
  end

  assign g_start     = (state == S_GAUSSIAN);
  assign d_start     = (state == S_DETECT);
  assign m_start     = (state == S_MATCH);
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign buffer_mode = state;

endmodule

// File: tb/tb_sift_phase_sequencer.sv
// -----------------------------------------------------------------------------
// tb_sift_phase_sequencer
// Directed bench for sift_phase_sequencer (N_SCALES=4, ADDR_W=9,
// TIMEOUT_CYC=16). Inputs change 1 time unit after the rising edge; outputs
// are sampled at the same point, i.e. reflecting the state just registered.
// The watchdog scenario is selected by SIFT_SEQ_TIMEOUT_EN.
// -----------------------------------------------------------------------------
module tb_sift_phase_sequencer;

  localparam int N  = 4;
  localparam int AW = 9;

  logic            clk = 1'b0;
  logic            rst, start, abort, d_done, m_done, g_buf_we, d_buf_we;
  logic [2:0]      phase_en;
  logic [N-1:0]    g_done;
  logic [N*AW-1:0] g_blur_addr, d_blur_addr, blur_addr;
  logic [AW-1:0]   g_img_addr, d_img_addr, img_addr;
  logic            g_start, d_start, m_start, buffer_we, busy, done, err;
  logic [2:0]      buffer_mode;

  int n_cmp = 0;
  int n_bad = 0;

  sift_phase_sequencer #(.N_SCALES(N), .ADDR_W(AW), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .start(start), .phase_en(phase_en), .abort(abort),
    .g_done(g_done), .d_done(d_done), .m_done(m_done),
    .g_start(g_start), .d_start(d_start), .m_start(m_start),
    .g_blur_addr(g_blur_addr), .d_blur_addr(d_blur_addr),
    .g_img_addr(g_img_addr), .d_img_addr(d_img_addr),
    .g_buf_we(g_buf_we), .d_buf_we(d_buf_we),
    .blur_addr(blur_addr), .img_addr(img_addr), .buffer_we(buffer_we),
    .buffer_mode(buffer_mode), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // State-level check: mode, busy, done and the three phase levels.
  task automatic check_state(input string tag, input logic [2:0] st);
    check({tag, ".mode"}, 64'(buffer_mode), 64'(st));
    check({tag, ".busy"}, 64'(busy), 64'(st != 3'd0));
    check({tag, ".done"}, 64'(done), 64'(st == 3'd4));
    check({tag, ".st"}, 64'({g_start, d_start, m_start}),
          64'({st == 3'd1, st == 3'd2, st == 3'd3}));
  endtask

  task automatic check_mux_zero(input string tag);
    check({tag, ".blur0"}, 64'(blur_addr), 64'd0);
    check({tag, ".img0"},  64'(img_addr),  64'd0);
    check({tag, ".we0"},   64'(buffer_we), 64'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; abort = 1'b0; phase_en = 3'b000;
    g_done = 4'b0000; d_done = 1'b0; m_done = 1'b0;
    g_blur_addr = 36'h0; d_blur_addr = 36'h0; g_img_addr = 9'h0; d_img_addr = 9'h0;
    g_buf_we = 1'b0; d_buf_we = 1'b0;
    tick(); tick();
    check_state("reset", 3'd0);
    check("reset.err", 64'(err), 64'd0);
    check_mux_zero("reset");
    rst = 1'b0;
    tick();

    // Full run, lanes finishing on cycles 5, 9, 9, 14 after GAUSSIAN entry.
    phase_en = 3'b111; start = 1'b1;
    g_blur_addr = 36'h0ABCDE123; g_img_addr = 9'h155; g_buf_we = 1'b1;
    d_blur_addr = 36'h987654321; d_img_addr = 9'h0AA; d_buf_we = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k <= 14; k++) begin
      g_done = {k == 14, k == 9, k == 9, k == 5};
      check_state($sformatf("full.g%0d", k), 3'd1);
      tick();
      g_done = 4'b0000;
    end
    check_state("full.det", 3'd2);
    check("full.det_blur", 64'(blur_addr), 64'h987654321);
    check("full.det_img",  64'(img_addr),  64'h0AA);
    check("full.det_we",   64'(buffer_we), 64'd1);
    tick();
    check_state("full.det2", 3'd2);
    d_done = 1'b1; tick(); d_done = 1'b0;
    check_state("full.match", 3'd3);
    check_mux_zero("full.match");
    m_done = 1'b1; tick(); m_done = 1'b0;
    check_state("full.done", 3'd4);
    tick();
    check_state("full.idle", 3'd0);

    // MATCH only: GAUSSIAN/DETECT never active, memory controls stay zero.
    phase_en = 3'b100; start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check_state($sformatf("monly.m%0d", k), 3'd3);
      check_mux_zero($sformatf("monly.m%0d", k));
      tick();
    end
    m_done = 1'b1; tick(); m_done = 1'b0;
    check_state("monly.done", 3'd4);
    check_mux_zero("monly.done");
    tick();
    check_state("monly.idle", 3'd0);
    check_mux_zero("monly.idle");

    // No phases enabled: straight to DONE for a single cycle.
    phase_en = 3'b000; start = 1'b1; tick(); start = 1'b0;
    check_state("none.done", 3'd4);
    tick();
    check_state("none.idle", 3'd0);

    // Abort colliding with d_done: back to IDLE, no done, no MATCH.
    phase_en = 3'b111; start = 1'b1; tick(); start = 1'b0;
    g_done = 4'b1111; tick(); g_done = 4'b0000;
    check_state("abort.det", 3'd2);
    abort = 1'b1; d_done = 1'b1; tick(); abort = 1'b0; d_done = 1'b0;
    check_state("abort.idle", 3'd0);
    tick();
    check_state("abort.idle2", 3'd0);

    // Abort together with start in IDLE: nothing starts.
    phase_en = 3'b001; start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check_state("abst.idle", 3'd0);

    // Start held while busy; lanes all address 0x0AB.
    g_blur_addr = {4{9'h0AB}}; g_img_addr = 9'h012; g_buf_we = 1'b0;
    phase_en = 3'b001; start = 1'b1; tick();
    for (int k = 0; k < 3; k++) begin
      check_state($sformatf("hold.g%0d", k), 3'd1);
      check($sformatf("hold.blur%0d", k), 64'(blur_addr), 64'({4{9'h0AB}}));
      check($sformatf("hold.img%0d", k), 64'(img_addr), 64'h012);
      check($sformatf("hold.we%0d", k), 64'(buffer_we), 64'd0);
      tick();
    end
    g_done = 4'b1111; tick(); g_done = 4'b0000;
    check_state("hold.done", 3'd4);
    start = 1'b0; tick();
    check_state("hold.idle", 3'd0);

    // Reset in the middle of a run: immediate IDLE, no done.
    phase_en = 3'b100; start = 1'b1; tick(); start = 1'b0;
    check_state("mrst.match", 3'd3);
    rst = 1'b1; tick(); rst = 1'b0;
    check_state("mrst.idle", 3'd0);
    tick();

`ifdef SIFT_SEQ_TIMEOUT_EN
    // Watchdog: GAUSSIAN with no g_done returns to IDLE after 16 cycles.
    phase_en = 3'b001; start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 16; k++) begin
      check_state($sformatf("wd.g%0d", k), 3'd1);
      check($sformatf("wd.err%0d", k), 64'(err), 64'd0);
      tick();
    end
    check_state("wd.idle", 3'd0);
    check("wd.err_set", 64'(err), 64'd1);
    tick();
    check("wd.err_sticky", 64'(err), 64'd1);
    start = 1'b1; tick(); start = 1'b0;
    check_state("wd.restart", 3'd1);
    check("wd.err_clr", 64'(err), 64'd0);
    abort = 1'b1; tick(); abort = 1'b0;
    check_state("wd.abort", 3'd0);
`else
    // Without the watchdog a stalled phase waits indefinitely, err stays 0.
    phase_en = 3'b001; start = 1'b1; tick(); start = 1'b0;
    for (int k = 0; k < 20; k++) tick();
    check_state("nowd.g", 3'd1);
    check("nowd.err", 64'(err), 64'd0);
    abort = 1'b1; tick(); abort = 1'b0;
    check_state("nowd.abort", 3'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
